// File: rtl/div_pkg.sv
// Shared widths, FSM state type and overflow result constants for the
// sequential 16/8 restoring divider.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int STEPS      = 8;
    localparam int CNT_W      = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Result presented when the divisor is zero or the quotient cannot fit
    localparam logic [DIVISOR_W-1:0] Q_OVF = 8'hFF;
    localparam logic [DIVISOR_W-1:0] R_OVF = 8'h00;

endpackage : div_pkg

// File: rtl/div_16x8_seq_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the partial
// remainder extended by the next dividend bit, keep the difference if it does
// not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 in_bit,
    input  logic [DIVISOR_W-1:0] div,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0] trial;

    // Bit 8 of the 9-bit difference is the borrow while rem < div holds
    always_comb begin
        trial    = {rem, in_bit} - {1'b0, div};
        qbit     = ~trial[DIVISOR_W];
        rem_next = qbit ? trial[DIVISOR_W-1:0] : {rem[DIVISOR_W-2:0], in_bit};
    end

endmodule : div_step

// File: rtl/div_16x8_seq.sv
// Sequential 16-bit by 8-bit restoring divider with valid/ready on both
// sides. Fixed latency: 8 step cycles regardless of data or overflow.
module div_16x8_seq
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf
);

    div_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIVISOR_W-1:0] rem_q, rem_d;
    logic [DIVISOR_W-1:0] sh_q, sh_d;
    logic [DIVISOR_W-1:0] div_q, div_d;
    logic                 ovf_q, ovf_d;

    logic [DIVISOR_W-1:0] step_rem;
    logic                 step_qbit;

    // Single shared step datapath, fed from the operand registers every cycle
    div_step u_step (
        .rem      (rem_q),
        .in_bit   (sh_q[DIVISOR_W-1]),
        .div      (div_q),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    // Handshake and result outputs depend on registered state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        quotient  = '0;
        remainder = '0;
        ovf       = 1'b0;
        if (state_q == DONE) begin
            quotient  = ovf_q ? Q_OVF : sh_q;
            remainder = ovf_q ? R_OVF : rem_q;
            ovf       = ovf_q;
        end
    end

    // Next-state, counter and operand register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        div_d   = div_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d   = divisor;
                    rem_d   = dividend[DIVIDEND_W-1:DIVISOR_W];
                    sh_d    = dividend[DIVISOR_W-1:0];
                    // High half >= divisor means the quotient needs > 8 bits
                    ovf_d   = (divisor == '0) ||
                              (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                sh_d  = {sh_q[DIVISOR_W-2:0], step_qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            div_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule : div_16x8_seq
